// File: rtl/exec_pkg.sv
// Shared types for the execute/write-back stage: opcodes, FSM states, flag indices.
// Optional feature macro: EXEC_SHIFT_EN (enables SLL/SRL and the SHIFT state).
package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLT = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_SHIFT = 3'd3,
        S_WRITE = 3'd4
    } state_e;

    // Bit positions inside flags = {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic isLegalOp(input logic [3:0] op);
`ifdef EXEC_SHIFT_EN
        return (op <= 4'(OP_SRL));
`else
        return (op <= 4'(OP_SLT));
`endif
    endfunction

endpackage

// File: rtl/exec_stage_alu32.sv
// Combinational 32-bit ALU for ADD/SUB/AND/OR/XOR/SLT with N/Z/C/V flags.
module alu32
    import exec_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  opcode_e     op,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    logic        isSub;
    logic [32:0] sum;
    logic        carry;
    logic        ovf;

    always_comb begin
        isSub  = (op == OP_SUB);
        // SUB is A + ~B + 1, so carry out of bit 32 means "no borrow"
        sum    = {1'b0, a} + {1'b0, (isSub ? ~b : b)} + {32'd0, isSub};
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                result = sum[31:0];
                carry  = sum[32];
                ovf    = (a[31] == (b[31] ^ isSub)) && (sum[31] != a[31]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
        flags         = '0;
        flags[FLAG_N] = result[31];
        flags[FLAG_Z] = (result == 32'd0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/exec_stage.sv
// Multi-cycle execute/write-back stage: IDLE -> READ -> EXEC -> [SHIFT] -> WRITE.
// Optional feature macro: EXEC_SHIFT_EN (iterative SLL/SRL; otherwise opcodes 6/7 are illegal).
module exec_stage
    import exec_pkg::*;
#(
    parameter int SHIFT_MAX = 31
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        opValid,
    output logic        opReady,
    input  logic [3:0]  opCode,
    input  logic [4:0]  srcA,
    input  logic [4:0]  srcB,
    input  logic [4:0]  dest,
    output logic [4:0]  regReadSel0,
    output logic [4:0]  regReadSel1,
    input  logic [31:0] regReadData0,
    input  logic [31:0] regReadData1,
    output logic [4:0]  regWriteSel,
    output logic        writeEnable,
    output logic [31:0] writeData,
    output logic        done,
    output logic        illegal,
    output logic [3:0]  flags
);

    if (SHIFT_MAX < 0 || SHIFT_MAX > 31) begin : gShiftMaxCheck
        $error("exec_stage: SHIFT_MAX must be in 0..31");
    end

    state_e      state, stateNext;
    logic [3:0]  opReg;
    logic [4:0]  destReg;
    logic        legalReg;
    logic [31:0] opA, opB;
    logic [31:0] aluResult;
    logic [3:0]  aluFlags;
    logic [31:0] resultNext;
    logic [3:0]  flagsNext;

    alu32 uAlu (
        .a      (opA),
        .b      (opB),
        .op     (opcode_e'(opReg)),
        .result (aluResult),
        .flags  (aluFlags)
    );

`ifdef EXEC_SHIFT_EN
    localparam logic [4:0] ShiftMax = 5'(SHIFT_MAX);

    logic [4:0]  shCnt;
    logic [4:0]  shiftAmt;
    logic [31:0] shifted;
    logic        shiftOut;
    logic        isSll;
    logic        isShift;

    always_comb begin
        isSll    = (opReg == OP_SLL);
        isShift  = isSll || (opReg == OP_SRL);
        shiftAmt = (opB[4:0] > ShiftMax) ? ShiftMax : opB[4:0];
        shifted  = isSll ? {opA[30:0], 1'b0} : {1'b0, opA[31:1]};
        shiftOut = isSll ? opA[31] : opA[0];
    end
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext  = state;
        resultNext = aluResult;
        flagsNext  = aluFlags;
        case (state)
            S_IDLE:  if (opValid) stateNext = S_READ;
            S_READ:  stateNext = S_EXEC;
            S_EXEC: begin
                stateNext = S_WRITE;
`ifdef EXEC_SHIFT_EN
                if (isShift) begin
                    resultNext = opA;
                    flagsNext  = {opA[31], (opA == 32'd0), 1'b0, 1'b0};
                    if (shiftAmt != 5'd0) stateNext = S_SHIFT;
                end
`endif
            end
`ifdef EXEC_SHIFT_EN
            S_SHIFT: begin
                resultNext = shifted;
                flagsNext  = {shifted[31], (shifted == 32'd0), shiftOut, 1'b0};
                if (shCnt == 5'd1) stateNext = S_WRITE;
            end
`endif
            S_WRITE: stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    assign opReady     = (state == S_IDLE);
    assign done        = (state == S_WRITE);
    assign illegal     = done && !legalReg;
    assign writeEnable = done && legalReg && (regWriteSel != 5'd0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            opReg       <= '0;
            destReg     <= '0;
            legalReg    <= 1'b0;
            regReadSel0 <= '0;
            regReadSel1 <= '0;
            regWriteSel <= '0;
            writeData   <= '0;
            flags       <= '0;
        end else begin
            state <= stateNext;
            if (state == S_IDLE && opValid) begin
                opReg       <= opCode;
                legalReg    <= isLegalOp(opCode);
                regReadSel0 <= srcA;
                regReadSel1 <= srcB;
                destReg     <= dest;
            end
            // Result, select and flags are loaded once on entry to WRITE and then held
            if (stateNext == S_WRITE) begin
                writeData   <= resultNext;
                regWriteSel <= destReg;
                if (legalReg) flags <= flagsNext;
            end
        end
    end

    // NOTE: operand/shift registers carry no reset; they are always loaded before they are consumed.
    always_ff @(posedge clk) begin
        if (state == S_READ) begin
            opA <= regReadData0;
            opB <= regReadData1;
        end
`ifdef EXEC_SHIFT_EN
        if (state == S_EXEC) shCnt <= shiftAmt;
        if (state == S_SHIFT) begin
            opA   <= shifted;
            shCnt <= shCnt - 5'd1;
        end
`endif
    end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: table-driven ops against a behavioural register file.
module tb_exec_stage;
    import exec_pkg::*;

`ifdef EXEC_SHIFT_EN
    localparam bit ShiftOn = 1'b1;
`else
    localparam bit ShiftOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        opValid;
    logic        opReady;
    logic [3:0]  opCode;
    logic [4:0]  srcA, srcB, dest;
    logic [4:0]  regReadSel0, regReadSel1;
    logic [31:0] regReadData0, regReadData1;
    logic [4:0]  regWriteSel;
    logic        writeEnable;
    logic [31:0] writeData;
    logic        done;
    logic        illegal;
    logic [3:0]  flags;

    exec_stage #(.SHIFT_MAX(31)) dut (
        .clk          (clk),
        .rst          (rst),
        .opValid      (opValid),
        .opReady      (opReady),
        .opCode       (opCode),
        .srcA         (srcA),
        .srcB         (srcB),
        .dest         (dest),
        .regReadSel0  (regReadSel0),
        .regReadSel1  (regReadSel1),
        .regReadData0 (regReadData0),
        .regReadData1 (regReadData1),
        .regWriteSel  (regWriteSel),
        .writeEnable  (writeEnable),
        .writeData    (writeData),
        .done         (done),
        .illegal      (illegal),
        .flags        (flags)
    );

    always #5 clk = ~clk;

    // Register file model: R0 reads as zero, bench-side preload port
    logic [31:0] rf [32];
    logic        tbWe;
    logic [4:0]  tbSel;
    logic [31:0] tbData;
    int          weCount = 0;
    int          acceptCount = 0;

    assign regReadData0 = (regReadSel0 == 5'd0) ? 32'd0 : rf[regReadSel0];
    assign regReadData1 = (regReadSel1 == 5'd0) ? 32'd0 : rf[regReadSel1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else begin
            if (writeEnable) rf[regWriteSel] <= writeData;
            if (tbWe) rf[tbSel] <= tbData;
        end
        if (writeEnable) weCount <= weCount + 1;
        if (opValid && opReady && !rst) acceptCount <= acceptCount + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [4:0] sel, input logic [31:0] data);
        @(negedge clk);
        tbWe = 1'b1; tbSel = sel; tbData = data;
        @(posedge clk); #1;
        tbWe = 1'b0;
    endtask

    // Issues one op and returns what the DUT showed in its done cycle; lat is the cycle index
    // counted with the cycle after the acceptance edge as 1.
    task automatic runOp(input logic [3:0] op, input logic [4:0] sa, input logic [4:0] sb,
                         input logic [4:0] d, input bit hold, output int lat,
                         output logic [31:0] wd, output logic we, output logic ill,
                         output logic [4:0] wsel);
        @(negedge clk);
        check("opReady before issue", 32'(opReady), 32'd1);
        opCode = op; srcA = sa; srcB = sb; dest = d; opValid = 1'b1;
        @(posedge clk); #1;
        if (!hold) opValid = 1'b0;
        check("regReadSel0 in READ", 32'(regReadSel0), 32'(sa));
        check("regReadSel1 in READ", 32'(regReadSel1), 32'(sb));
        lat = 1; wd = '0; we = 1'b0; ill = 1'b0; wsel = '0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done) begin
            wd = writeData; we = writeEnable; ill = illegal; wsel = regWriteSel;
        end else begin
            check("done timeout", 32'd0, 32'd1);
        end
        opValid = 1'b0;
        @(posedge clk); #1;
        check("done single cycle", 32'(done), 32'd0);
        check("writeEnable single cycle", 32'(writeEnable), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  sa, sb, d;
        logic [31:0] a, b;
        logic [31:0] expData;
        logic [3:0]  expFlags;
        bit          legal;
        bit          isShift;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] op, input logic [4:0] sa, input logic [4:0] sb,
                                input logic [4:0] d, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] e, input logic [3:0] f, input bit legal,
                                input bit sh, input int lat);
        vec_t v;
        v.op = op; v.sa = sa; v.sb = sb; v.d = d; v.a = a; v.b = b;
        v.expData = e; v.expFlags = f; v.legal = legal; v.isShift = sh; v.lat = lat;
        return v;
    endfunction

    initial begin
        int          lat;
        logic [31:0] wd;
        logic        we, ill;
        logic [4:0]  wsel;
        logic [3:0]  modelFlags;
        bit          legal;
        int          expLat;
        int          count0;

        //               op      sa    sb    d      a             b             result        flags    L  sh lat
        vecs[0]  = mk(4'd0,  5'd1, 5'd2, 5'd3,  32'd5,        32'd7,        32'd12,       4'b0000, 1, 0, 3);
        vecs[1]  = mk(4'd0,  5'd1, 5'd2, 5'd3,  32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b1001, 1, 0, 3);
        vecs[2]  = mk(4'd1,  5'd2, 5'd2, 5'd4,  32'd0,        32'd1,        32'd0,        4'b0110, 1, 0, 3);
        vecs[3]  = mk(4'd1,  5'd1, 5'd2, 5'd5,  32'd3,        32'd5,        32'hFFFFFFFE, 4'b1000, 1, 0, 3);
        vecs[4]  = mk(4'd2,  5'd1, 5'd2, 5'd6,  32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 4'b0000, 1, 0, 3);
        vecs[5]  = mk(4'd3,  5'd1, 5'd2, 5'd7,  32'hF0000000, 32'd1,        32'hF0000001, 4'b1000, 1, 0, 3);
        vecs[6]  = mk(4'd4,  5'd1, 5'd2, 5'd8,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'd0,        4'b0100, 1, 0, 3);
        vecs[7]  = mk(4'd5,  5'd1, 5'd2, 5'd9,  32'hFFFFFFFF, 32'd1,        32'd1,        4'b0000, 1, 0, 3);
        vecs[8]  = mk(4'd5,  5'd1, 5'd2, 5'd9,  32'd5,        32'd3,        32'd0,        4'b0100, 1, 0, 3);
        vecs[9]  = mk(4'd0,  5'd1, 5'd2, 5'd10, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b0110, 1, 0, 3);
        vecs[10] = mk(4'd9,  5'd1, 5'd2, 5'd11, 32'd1,        32'd2,        32'd0,        4'b0000, 0, 0, 3);
        vecs[11] = mk(4'd15, 5'd1, 5'd2, 5'd11, 32'd1,        32'd2,        32'd0,        4'b0000, 0, 0, 3);
        vecs[12] = mk(4'd6,  5'd1, 5'd2, 5'd12, 32'd1,        32'd31,       32'h80000000, 4'b1000, 1, 1, 34);
        vecs[13] = mk(4'd6,  5'd1, 5'd2, 5'd12, 32'd1,        32'd0,        32'd1,        4'b0000, 1, 1, 3);
        vecs[14] = mk(4'd7,  5'd1, 5'd2, 5'd13, 32'h80000001, 32'd1,        32'h40000000, 4'b0010, 1, 1, 4);
        vecs[15] = mk(4'd7,  5'd1, 5'd2, 5'd13, 32'h00000018, 32'd4,        32'd1,        4'b0010, 1, 1, 7);
        vecs[16] = mk(4'd6,  5'd1, 5'd2, 5'd14, 32'd3,        32'h00000021, 32'd6,        4'b0000, 1, 1, 4);
        vecs[17] = mk(4'd0,  5'd1, 5'd2, 5'd0,  32'd5,        32'd7,        32'd12,       4'b0000, 1, 0, 3);

        rst = 1'b1; opValid = 1'b0; opCode = '0; srcA = '0; srcB = '0; dest = '0;
        tbWe = 1'b0; tbSel = '0; tbData = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset opReady", 32'(opReady), 32'd1);
        check("reset writeEnable", 32'(writeEnable), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset illegal", 32'(illegal), 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        check("reset regReadSel0", 32'(regReadSel0), 32'd0);
        check("reset regReadSel1", 32'(regReadSel1), 32'd0);
        check("reset regWriteSel", 32'(regWriteSel), 32'd0);
        check("reset writeData", writeData, 32'd0);
        rst = 1'b0;
        modelFlags = 4'b0000;

        for (int i = 0; i < NV; i++) begin
            legal  = vecs[i].legal && (!vecs[i].isShift || ShiftOn);
            expLat = legal ? vecs[i].lat : 3;
            preload(5'd1, vecs[i].a);
            preload(5'd2, vecs[i].b);
            runOp(vecs[i].op, vecs[i].sa, vecs[i].sb, vecs[i].d, 1'b0, lat, wd, we, ill, wsel);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(expLat));
            check($sformatf("v%0d writeEnable", i), 32'(we), 32'(legal && vecs[i].d != 5'd0));
            check($sformatf("v%0d illegal", i), 32'(ill), 32'(!legal));
            check($sformatf("v%0d regWriteSel", i), 32'(wsel), 32'(vecs[i].d));
            if (legal) begin
                check($sformatf("v%0d writeData", i), wd, vecs[i].expData);
                check($sformatf("v%0d writeData hold", i), writeData, vecs[i].expData);
                modelFlags = vecs[i].expFlags;
            end
            check($sformatf("v%0d flags", i), 32'(flags), 32'(modelFlags));
        end

        // R0 stays zero and reads as zero; R1 still holds 5 from the last vector
        check("R0 never written", rf[0], 32'd0);
        runOp(4'd0, 5'd0, 5'd1, 5'd15, 1'b0, lat, wd, we, ill, wsel);
        check("R0+R1 writeData", wd, 32'd5);
        check("R0+R1 writeEnable", 32'(we), 32'd1);

        // Dependent op reads the value just written back
        runOp(4'd0, 5'd15, 5'd1, 5'd16, 1'b0, lat, wd, we, ill, wsel);
        check("RAW writeData", wd, 32'd10);
        check("RAW regfile", rf[16], 32'd10);

        // opValid held through the whole op: only one acceptance
        count0 = acceptCount;
        runOp(4'd0, 5'd16, 5'd1, 5'd17, 1'b1, lat, wd, we, ill, wsel);
        check("held valid writeData", wd, 32'd15);
        check("held valid acceptances", 32'(acceptCount - count0), 32'd1);

        // Reset in the middle of an op (SHIFT when shifts exist, EXEC otherwise)
        preload(5'd1, 32'd1);
        preload(5'd2, 32'd31);
        @(negedge clk);
        opCode = ShiftOn ? 4'(OP_SLL) : 4'(OP_ADD);
        srcA = 5'd1; srcB = 5'd2; dest = 5'd20; opValid = 1'b1;
        @(posedge clk); #1;
        opValid = 1'b0;
        count0 = weCount;
        repeat (ShiftOn ? 5 : 1) @(posedge clk);
        #1;
        check("busy before reset", 32'(opReady), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid-op reset opReady", 32'(opReady), 32'd1);
        check("mid-op reset done", 32'(done), 32'd0);
        check("mid-op reset flags", 32'(flags), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("mid-op reset no write", 32'(weCount - count0), 32'd0);
        check("mid-op reset still idle", 32'(opReady), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/exec_stage.md
# exec_stage

Multi-cycle execute/write-back stage directly downstream of the 32x32 register file. Accepts one issued operation at a time, drives the register file's two read selects, captures both operands, computes the result (single-cycle ALU ops or an iterative shifter), and writes the result back through the register file write port. It also publishes condition flags and a completion pulse to the sequencer upstream.

## Interface
Parameters:
- `SHIFT_MAX`, 31: largest shift amount honoured. Operand B[4:0] is clamped to this value.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `opValid`  in  1  issue request
- `opReady`  out  1  stage can accept an op; high only in IDLE
- `opCode`  in  4  operation select
- `srcA`, `srcB`  in  5  source register numbers
- `dest`  in  5  destination register number
- `regReadSel0`, `regReadSel1`  out  5  read selects to the register file
- `regReadData0`, `regReadData1`  in  32  read data from the register file
- `regWriteSel`  out  5  write select
- `writeEnable`  out  1  write strobe, one cycle
- `writeData`  out  32  write data
- `done`  out  1  one-cycle completion pulse
- `illegal`  out  1  one-cycle pulse, coincident with `done`, for an unsupported opcode
- `flags`  out  4  {N,Z,C,V}, sticky until the next legal completion

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed; result 1 or 0)
  - 6 SLL, 7 SRL (amount = B[4:0])
  - 8–15 illegal
- Handshake: the op is accepted on an edge where `opValid`&&`opReady`. `opCode`/`srcA`/`srcB`/`dest` are latched at acceptance. `opValid` while busy is ignored, with no queueing.
- FSM states:
  - IDLE → READ on accept.
  - READ → EXEC. The latched `srcA`/`srcB` drive `regReadSel0/1`, and both data words are captured at the end of READ.
  - EXEC → WRITE for opcodes 0–5 and illegal opcodes. For SLL/SRL, EXEC → SHIFT, or → WRITE if the amount is 0.
  - SHIFT shifts 1 bit per cycle and decrements a 5-bit counter. It moves to WRITE when the counter reaches 0.
  - WRITE → IDLE.
- Arithmetic: 33-bit add; SUB is A + ~B + 1.
  - C = bit 32 of that sum (SUB: 1 = no borrow).
  - V = signed overflow for ADD/SUB; 0 for all other ops.
  - C is 0 for logic ops and SLT.
  - For shifts, C = last bit shifted out (0 if the amount is 0).
  - Z = (result==0); N = result[31].
- WRITE cycle:
  - `done`=1 and `regWriteSel`=`dest`.
  - `writeData`=result.
  - `writeEnable`=1 only if the op is legal and `dest`≠0. Writes to register 0 are suppressed.
  - `flags` update in this cycle for legal ops only.
- Illegal opcode: `illegal`=`done`=1, no write, flags unchanged.
- Reset mid-operation: return to IDLE next edge; the pending write is discarded.

## Timing
- Reset values: `opReady`=1 (IDLE after reset), `writeEnable`=0, `done`=0, `illegal`=0, `flags`=0. `regReadSel0/1`, `regWriteSel` and `writeData` are all 0.
- Latency: acceptance edge T, READ cycle T+1, EXEC T+2, WRITE T+3, so `done` is high in the 3rd cycle after acceptance. A shift by n adds n cycles.
- Throughput: the next op can be accepted on the edge ending WRITE+1 (IDLE), so back-to-back ops issue every 4 cycles.
- Read-after-write: a dependent op's READ falls at least 2 cycles after the prior write edge, so no bypass is needed.
- `writeData`/`regWriteSel` hold their values outside WRITE. `writeEnable`, `done` and `illegal` are strictly single-cycle.

## Configuration
- `EXEC_SHIFT_EN` defined: SHIFT state and opcodes 6/7 implemented as described.
- `EXEC_SHIFT_EN` undefined: opcodes 6/7 are treated as illegal and the SHIFT state is not built.

## Structure
- Package `exec_pkg` holds:
  - opcode enum (`OP_ADD`…`OP_SRL`)
  - FSM state enum
  - flag bit indices `FLAG_N`, `FLAG_Z`, `FLAG_C`, `FLAG_V`
- Sub-module `alu32` is purely combinational: ops 0–5 plus N/Z/C/V. The FSM, operand registers and shifter live in `exec_stage`.

## Test plan
- R1=5, R2=7, ADD dest R3 → `writeEnable` at T+3, `writeData`=12, flags {0,0,0,0}.
- R1=0x7FFFFFFF, R2=1, ADD → result 0x80000000, N=1, V=1; then SUB R2−R2 → 0, Z=1, C=1.
- R1=0x1, R2=31, SLL (`EXEC_SHIFT_EN` defined) → `done` at T+34, result 0x80000000. Same op with R2=0 → `done` at T+3, result 1.
- ADD with dest=0 → `done`=1, `writeEnable`=0; a subsequent read of R0 returns 0.
- Opcode 9 → `illegal`=`done`=1, no write, flags unchanged. `opValid` held during busy → exactly one acceptance per op.
- Assert `rst` during SHIFT → IDLE next cycle, `opReady`=1, no write.
